// File: rtl/pipe_pkg.sv
// Shared control-word layout for all pipeline stage registers.
// No logic; field positions here must match the decode stage.
package pipe_pkg;

    localparam int PIPE_CTRL_W = 24;

    localparam int REG_WR_BIT = 5;
    localparam int MEM_WR_BIT = 15;
    localparam int MEM_RD_BIT = 16;

    // MSB first; packs to exactly PIPE_CTRL_W bits.
    typedef struct packed {
        logic [2:0] spare;
        logic       ext_op;
        logic       lu_op;
        logic [1:0] mem_to_reg;
        logic       mem_rd;
        logic       mem_wr;
        logic       sign;
        logic [5:0] alu_fun;
        logic       alu_src2;
        logic       alu_src1;
        logic       reg_wr;
        logic [1:0] reg_dst;
        logic [2:0] pc_src;
    } ctrl_t;

    // True when a control word would touch architectural state.
    function automatic logic ctrl_has_side_effect(input logic [PIPE_CTRL_W-1:0] c);
        return c[REG_WR_BIT] | c[MEM_WR_BIT] | c[MEM_RD_BIT];
    endfunction

endpackage

// File: rtl/pipe_stage_entry.sv
// One storage slot (valid + ctrl + data); clear > load > drain.
// Latency 1 cycle; no handshake of its own, the parent decides load/drain.
module pipe_stage_entry
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = PIPE_CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic              drain,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // Control is zeroed whenever the slot empties; data is left alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= ld_ctrl;
            data  <= ld_data;
        end else if (drain) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with stall/flush; PIPE_STAGE_SKID_BUF_EN adds a skid entry.
// Latency 1 cycle; in_ready = !stall && room (combinational on out_ready unless skid built).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = PIPE_CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
);

    logic              accept;
    logic              consume;
    logic              out_load;
    logic              out_drain;
    logic [CTRL_W-1:0] out_ld_ctrl;
    logic [DATA_W-1:0] out_ld_data;

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_BUF_EN
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              skid_load;
    logic              skid_drain;

    // Ready depends only on registered state, breaking the out_ready path.
    assign in_ready    = !stall && !skid_valid;
    assign skid_load   = accept && out_valid && !out_ready;
    assign skid_drain  = consume && skid_valid;
    assign out_load    = skid_drain || (accept && (!out_valid || out_ready));
    assign out_drain   = consume;
    assign out_ld_ctrl = skid_valid ? skid_ctrl : in_ctrl;
    assign out_ld_data = skid_valid ? skid_data : in_data;

    pipe_stage_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .clear   (flush),
        .load    (skid_load),
        .drain   (skid_drain),
        .ld_ctrl (in_ctrl),
        .ld_data (in_data),
        .valid   (skid_valid),
        .ctrl    (skid_ctrl),
        .data    (skid_data)
    );
`else
    assign in_ready    = !stall && (!out_valid || out_ready);
    assign out_load    = accept;
    assign out_drain   = consume;
    assign out_ld_ctrl = in_ctrl;
    assign out_ld_data = in_data;
`endif

    pipe_stage_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_out (
        .clk     (clk),
        .reset   (reset),
        .clear   (flush),
        .load    (out_load),
        .drain   (out_drain),
        .ld_ctrl (out_ld_ctrl),
        .ld_data (out_ld_data),
        .valid   (out_valid),
        .ctrl    (out_ctrl),
        .data    (out_data)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a queue of accepted entries is the reference.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int DW = 32;
    localparam int CW = PIPE_CTRL_W;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          stall = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;

    ent_t          q[$];
    logic [DW-1:0] last_data = '0;
    logic          mon_en = 1'b0;
    int            n_cmp = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W (DW),
        .CTRL_W (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .stall     (stall),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock of stimulus; the stage occupancy is simply the queue depth.
    task automatic cycle(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic ordy, input logic stl, input logic fl, input logic rst);
        logic exp_rdy;
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        stall     = stl;
        flush     = fl;
        reset     = rst;
        #2;
`ifdef PIPE_STAGE_SKID_BUF_EN
        exp_rdy = !stl && (q.size() < 2);
`else
        exp_rdy = !stl && (q.size() == 0 || ordy);
`endif
        if (mon_en) chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        #4;
        if (rst) begin
            q.delete();
            last_data = '0;
        end else if (fl) begin
            q.delete();
        end else if (iv && exp_rdy) begin
            q.push_back('{ctrl: c, data: d});
        end
        mon_en = 1'b1;
    endtask

    // Monitor: whatever the DUT presents must be the oldest surviving entry.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (q.size() > 0) begin
                    chk("out_valid", 64'(out_valid), 64'(1'b1));
                    chk("out_ctrl", 64'(out_ctrl), 64'(q[0].ctrl));
                    chk("out_data", 64'(out_data), 64'(q[0].data));
                    last_data = q[0].data;
                    if (out_ready && !flush && !reset) void'(q.pop_front());
                end else begin
                    chk("bubble_valid", 64'(out_valid), 64'(1'b0));
                    chk("bubble_ctrl", 64'(out_ctrl), 64'(0));
                    chk("bubble_side_effect", 64'(ctrl_has_side_effect(out_ctrl)), 64'(1'b0));
                    chk("bubble_data", 64'(out_data), 64'(last_data));
                end
            end
        end
    end

    function automatic logic [CW-1:0] rand_ctrl();
        ctrl_t rc;
        rc = ctrl_t'($urandom);
        rc.reg_wr = 1'b1;
        return rc;
    endfunction

    initial begin
        // Reset held two cycles while upstream offers data.
        cycle(1'b1, rand_ctrl(), 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, rand_ctrl(), 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_ctrl", 64'(out_ctrl), 64'(0));
        chk("rst_data", 64'(out_data), 64'(0));

        // Back-to-back with out_ready high: no bubbles.
        cycle(1'b1, rand_ctrl(), 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, rand_ctrl(), 32'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("b2b_0", 64'(out_data), 64'(32'h10));
        cycle(1'b1, rand_ctrl(), 32'h12, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("b2b_1", 64'(out_data), 64'(32'h11));
        chk("b2b_1_valid", 64'(out_valid), 64'(1'b1));
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("b2b_2", 64'(out_data), 64'(32'h12));
        chk("b2b_2_valid", 64'(out_valid), 64'(1'b1));
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Hold 0xA5 under stall, then flush together with stall and a new entry.
        cycle(1'b1, rand_ctrl(), 32'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, rand_ctrl(), $urandom, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("stall_data", 64'(out_data), 64'(32'hA5));
            chk("stall_valid", 64'(out_valid), 64'(1'b1));
            chk("stall_in_ready", 64'(in_ready), 64'(1'b0));
        end
        cycle(1'b1, rand_ctrl(), 32'h77, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("flush_valid", 64'(out_valid), 64'(1'b0));
        chk("flush_ctrl", 64'(out_ctrl), 64'(0));
        chk("flush_data", 64'(out_data), 64'(32'hA5));

`ifdef PIPE_STAGE_SKID_BUF_EN
        // Second entry lands in the skid slot and drains in order.
        cycle(1'b1, rand_ctrl(), 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, rand_ctrl(), 32'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("skid_full_ready", 64'(in_ready), 64'(1'b0));
        chk("skid_head", 64'(out_data), 64'(32'h1));
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("skid_second", 64'(out_data), 64'(32'h2));
        chk("skid_second_valid", 64'(out_valid), 64'(1'b1));
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("skid_empty", 64'(out_valid), 64'(1'b0));
`endif

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 10000; i++) begin
            cycle(($urandom_range(99, 0) < 70) ? 1'b1 : 1'b0,
                  rand_ctrl(), $urandom,
                  ($urandom_range(99, 0) < 60) ? 1'b1 : 1'b0,
                  ($urandom_range(99, 0) < 20) ? 1'b1 : 1'b0,
                  ($urandom_range(99, 0) < 3) ? 1'b1 : 1'b0,
                  ($urandom_range(999, 0) < 5) ? 1'b1 : 1'b0);
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("drained", 64'(q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the datapath payload (operands, immediates, PC).
REQ-002 SHALL have parameter CTRL_W, default 24: width of the control payload (PCSrc, RegDst, RegWr, ALUFun, MemWr, MemRd, MemToReg, ...).
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1: discard all held entries (branch/jump squash).
REQ-006 SHALL have port stall, input, 1: hazard-unit hold; blocks new acceptance.
REQ-007 SHALL have port in_valid, input, 1: upstream entry present.
REQ-008 SHALL have port in_ready, output, 1: stage can accept this cycle.
REQ-009 SHALL have port in_ctrl, input, CTRL_W: upstream control payload.
REQ-010 SHALL have port in_data, input, DATA_W: upstream datapath payload.
REQ-011 SHALL have port out_valid, output, 1: entry presented downstream.
REQ-012 SHALL have port out_ready, input, 1: downstream consumes this cycle.
REQ-013 SHALL have port out_ctrl, output, CTRL_W: presented control payload.
REQ-014 SHALL have port out_data, output, DATA_W: presented datapath payload.

Function
REQ-015 SHALL accept an entry when in_valid && in_ready, and SHALL complete a transfer out when out_valid && out_ready.
REQ-016 SHALL have a latency of exactly 1 cycle from acceptance into an empty stage to out_valid=1.
REQ-017 SHALL drive out_ctrl to all-zero whenever out_valid=0 (bubble), so a bubble never writes the register file or memory.
REQ-018 SHALL, without the skid buffer, drive in_ready = !stall && (!out_valid || out_ready) combinationally.
REQ-019 SHALL, when stall=1 and no flush, hold out_valid/out_ctrl/out_data unchanged unless the held entry is consumed; if it is consumed, out_valid SHALL go to 0 next cycle.
REQ-020 SHALL, when flush=1, set out_valid=0 and out_ctrl=0 next cycle and drop the incoming entry; flush SHALL take priority over stall, acceptance and consumption.
REQ-021 SHALL preserve out_data contents across flush and bubbles (not cleared); only control is zeroed.
REQ-022 SHALL, on simultaneous consumption and acceptance, replace the entry with no bubble (full throughput, 1 entry/cycle).
REQ-023 SHALL never duplicate, drop (except on flush) or reorder entries.

Reset
REQ-024 SHALL, while reset=1 at a clk edge, set out_valid=0, out_ctrl=0 and out_data=0, and empty the skid entry when present.
REQ-025 SHALL give reset priority over flush, stall and all handshakes, including mid-transfer.

Configuration
REQ-026 SHALL compile in a second (skid) entry when macro PIPE_STAGE_SKID_BUF_EN is defined: in_ready = !stall && !skid_valid (registered, no out_ready path); an entry accepted while out_valid && !out_ready SHALL go to the skid entry, and the skid entry SHALL move to the output entry in the cycle the output entry is consumed; flush SHALL clear both entries.
REQ-027 SHALL, with PIPE_STAGE_SKID_BUF_EN undefined, contain no skid storage and behave per REQ-018.

Structure
REQ-028 SHALL take the default CTRL_W and the control-field bit positions (ALUFun, MemToReg, RegDst, ...) from the shared package pipe_pkg, which all pipeline stage registers use.
REQ-029 SHALL implement each storage entry as a sub-module pipe_stage_entry (valid + ctrl + data with load/clear), instantiated once, or twice with the skid buffer.

Verification
REQ-030 SHALL cover: reset=1 for 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, out_data=0.
REQ-031 SHALL cover: out_ready=1, back-to-back in_data 0x10,0x11,0x12 -> same values on out_data on cycles 1,2,3, no bubbles.
REQ-032 SHALL cover: entry 0xA5 held, stall=1 for 3 cycles, out_ready=0 -> out_data=0xA5, out_valid=1 throughout, in_ready=0.
REQ-033 SHALL cover: flush=1 together with stall=1 and in_valid=1 -> next cycle out_valid=0, out_ctrl=0, out_data unchanged.
REQ-034 SHALL cover, with PIPE_STAGE_SKID_BUF_EN: out_ready=0, in_data 0x1,0x2 -> second entry stored in skid, in_ready=0; out_ready=1 -> 0x1 then 0x2 delivered in order.
REQ-035 SHALL cover: random in_valid/out_ready/stall over 10k cycles against a reference queue model -> no loss, duplication or reordering.
